// File: rtl/crc8_pkg.sv
// Shared constants and state encoding for the serial CRC-8 engine.
package crc8_pkg;

    localparam int CRC_W = 8;

    localparam logic [CRC_W-1:0] DEFAULT_POLY = 8'h07;
    localparam logic [CRC_W-1:0] DEFAULT_INIT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } crcState_e;

endpackage

// File: rtl/crc8_bit_step.sv
// One MSB-first CRC-8 shift step: feedback = crcIn[7] ^ inBit, then shift and
// conditionally fold in the polynomial.
module crc8_bit_step
    import crc8_pkg::*;
(
    input  logic [CRC_W-1:0] crcIn,
    input  logic             inBit,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] crcOut
);

    logic             feedback;
    logic [CRC_W-1:0] shifted;
    logic [CRC_W-1:0] polyMask;

    xor2_cell fbCell (
        .a (crcIn[CRC_W-1]),
        .b (inBit),
        .y (feedback)
    );

    assign shifted  = {crcIn[CRC_W-2:0], 1'b0};
    assign polyMask = poly & {CRC_W{feedback}};

    // One XOR cell per register bit merges the shifted value with the polynomial.
    for (genvar i = 0; i < CRC_W; i++) begin : gXor
        xor2_cell bitCell (
            .a (shifted[i]),
            .b (polyMask[i]),
            .y (crcOut[i])
        );
    end

endmodule

// File: rtl/xor2_cell.sv
// Two-input XOR gate cell, the basic building block of the CRC step network.
module xor2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 with valid/ready framing on input and a held result on output.
// Optional macro CRC8_CHECK_EN adds crc_ok, flagging a zero residue in HOLD.
module crc8_serial
    import crc8_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY,
    parameter logic [CRC_W-1:0] INIT = DEFAULT_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CRC_W-1:0] out_crc,
    output logic             busy
`ifdef CRC8_CHECK_EN
    ,
    output logic             crc_ok
`endif
);

    crcState_e        state;
    crcState_e        stateNext;
    logic [CRC_W-1:0] crc;
    logic [CRC_W-1:0] crcNext;
    logic [CRC_W-1:0] stepIn;
    logic [CRC_W-1:0] stepOut;
    logic             accept;

    // A new frame always starts from INIT, whatever the register holds.
    assign stepIn = (state == IDLE) ? INIT : crc;
    assign accept = in_valid && in_ready;

    crc8_bit_step stepUnit (
        .crcIn  (stepIn),
        .inBit  (in_bit),
        .poly   (POLY),
        .crcOut (stepOut)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            crc   <= INIT;
        end else begin
            state <= stateNext;
            crc   <= crcNext;
        end
    end

    always_comb begin
        stateNext = state;
        crcNext   = crc;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    crcNext   = stepOut;
                    stateNext = in_last ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (accept) begin
                    crcNext = stepOut;
                    if (in_last) begin
                        stateNext = HOLD;
                    end
                end
            end
            HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (out_ready) begin
                    stateNext = IDLE;
                    crcNext   = INIT;
                end
            end
            default: begin
                stateNext = IDLE;
                crcNext   = INIT;
            end
        endcase
    end

    assign out_crc = crc;

`ifdef CRC8_CHECK_EN
    assign crc_ok = (state == HOLD) && (crc == '0);
`endif

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: directed vectors plus random frames checked
// against a polynomial long-division reference model.
module tb_crc8_serial;

    localparam logic [7:0] POLY_V = 8'h07;
    localparam logic [7:0] INIT_V = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_crc;
    logic       busy;
`ifdef CRC8_CHECK_EN
    logic       crc_ok;
`endif

    int testsRun  = 0;
    int failCount = 0;
    bit msgBits[$];

    always #5 clk = ~clk;

    crc8_serial #(.POLY(POLY_V), .INIT(INIT_V)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_crc   (out_crc),
        .busy      (busy)
`ifdef CRC8_CHECK_EN
        ,
        .crc_ok    (crc_ok)
`endif
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Remainder of (message * x^8 + INIT * x^len) divided by x^8 + POLY.
    function automatic logic [7:0] refCrc(input int len);
        int         a[];
        int         g[9];
        logic [7:0] initV;
        logic [7:0] polyV;
        logic [7:0] rem;
        initV = INIT_V;
        polyV = POLY_V;
        a = new[len + 8];
        for (int i = 0; i < len + 8; i++) a[i] = (i < len) ? int'(msgBits[i]) : 0;
        for (int j = 0; j < 8; j++) a[j] = a[j] ^ int'(initV[7-j]);
        g[0] = 1;
        for (int j = 1; j <= 8; j++) g[j] = int'(polyV[8-j]);
        for (int i = 0; i < len; i++) begin
            if (a[i] != 0) begin
                for (int j = 0; j <= 8; j++) a[i+j] = a[i+j] ^ g[j];
            end
        end
        rem = '0;
        for (int j = 0; j < 8; j++) rem[7-j] = a[len+j][0];
        return rem;
    endfunction

    task automatic addByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) msgBits.push_back(b[i]);
    endtask

    task automatic applyStimulus(input int gapMin, input int gapMax);
        int n;
        int gaps;
        n = msgBits.size();
        for (int k = 0; k < n; k++) begin
            in_valid  = 1'b1;
            in_bit    = msgBits[k];
            in_last   = (k == n - 1);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b0;
            if (k == n - 1) begin
                checkOutput("outValidLatency", 8'(out_valid), 8'd1);
                checkOutput("frameCrc", out_crc, refCrc(n));
            end else begin
                checkOutput("busyInFrame", 8'(busy), 8'd1);
                checkOutput("prefixCrc", out_crc, refCrc(k + 1));
                gaps = $urandom_range(gapMin, gapMax);
                repeat (gaps) begin
                    in_bit  = 1'($urandom);
                    in_last = 1'($urandom);
                    @(posedge clk); #1;
                    checkOutput("gapHold", out_crc, refCrc(k + 1));
                    checkOutput("gapNoValid", 8'(out_valid), 8'd0);
                end
            end
        end
    endtask

    task automatic drainResult(input int holdCycles, input logic [7:0] expected);
        repeat (holdCycles) begin
            in_valid = 1'($urandom);
            in_bit   = 1'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("holdValid", 8'(out_valid), 8'd1);
            checkOutput("holdCrc", out_crc, expected);
            checkOutput("holdNotReady", 8'(in_ready), 8'd0);
            checkOutput("holdNotBusy", 8'(busy), 8'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("drainValidLow", 8'(out_valid), 8'd0);
        checkOutput("drainReady", 8'(in_ready), 8'd1);
        checkOutput("drainCrcInit", out_crc, INIT_V);
    endtask

    initial begin
        string s;
        int    len;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rstValid", 8'(out_valid), 8'd0);
        checkOutput("rstReady", 8'(in_ready), 8'd1);
        checkOutput("rstBusy", 8'(busy), 8'd0);
        checkOutput("rstCrc", out_crc, INIT_V);

        // Byte 0x01 with result taken immediately.
        msgBits.delete();
        addByte(8'h01);
        applyStimulus(0, 0);
        checkOutput("vec01", out_crc, 8'h07);
        drainResult(0, refCrc(msgBits.size()));

        // Standard check string.
        msgBits.delete();
        s = "123456789";
        for (int i = 0; i < s.len(); i++) addByte(s[i]);
        applyStimulus(0, 0);
        checkOutput("vecCheckStr", out_crc, 8'hF4);
        drainResult(0, refCrc(msgBits.size()));

        // Byte 0xFF with a gap after every bit.
        msgBits.delete();
        addByte(8'hFF);
        applyStimulus(1, 1);
        checkOutput("vecFFGapped", out_crc, 8'hF3);
        drainResult(0, refCrc(msgBits.size()));

        // Result held for 5 cycles while inputs toggle.
        msgBits.delete();
        addByte(8'h01);
        applyStimulus(0, 0);
        drainResult(5, 8'h07);

        // Single-bit frame goes straight to HOLD.
        msgBits.delete();
        msgBits.push_back(1'b1);
        applyStimulus(0, 0);
        checkOutput("singleBit", out_crc, 8'h07);
        drainResult(1, 8'h07);

        // Reset mid-frame, with a simultaneous valid bit.
        msgBits.delete();
        addByte(8'hA5);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_bit   = msgBits[k];
            in_last  = 1'b0;
            @(posedge clk); #1;
        end
        in_bit    = 1'b1;
        in_last   = 1'b1;
        out_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        checkOutput("midRstValid", 8'(out_valid), 8'd0);
        checkOutput("midRstBusy", 8'(busy), 8'd0);
        checkOutput("midRstReady", 8'(in_ready), 8'd1);
        checkOutput("midRstCrc", out_crc, INIT_V);
        msgBits.delete();
        addByte(8'h01);
        applyStimulus(0, 0);
        checkOutput("postRst01", out_crc, 8'h07);

        // Reset in HOLD discards the pending result.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("holdRstValid", 8'(out_valid), 8'd0);
        checkOutput("holdRstCrc", out_crc, INIT_V);

`ifdef CRC8_CHECK_EN
        msgBits.delete();
        addByte(8'h01);
        addByte(8'h07);
        applyStimulus(0, 0);
        checkOutput("crcOkGood", 8'(crc_ok), 8'd1);
        drainResult(0, refCrc(msgBits.size()));
        checkOutput("crcOkIdle", 8'(crc_ok), 8'd0);
        msgBits.delete();
        addByte(8'h01);
        addByte(8'h06);
        applyStimulus(0, 0);
        checkOutput("crcOkBad", 8'(crc_ok), 8'd0);
        drainResult(0, refCrc(msgBits.size()));
`endif

        // Random frames with random gaps and hold times.
        for (int f = 0; f < 20; f++) begin
            msgBits.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) msgBits.push_back(1'($urandom));
            applyStimulus(0, 2);
            drainResult($urandom_range(0, 3), refCrc(msgBits.size()));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
